// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte sources share one fixed-frame UART transmitter.
// It grants one byte at a time, pulses tx_start, then follows tx_busy to frame end or to a start timeout.
module uart_tx_arbiter #(
  parameter int N_REQ         = 2,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 16,
  localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    done,
  output logic                    err
);

  localparam int                CNT_W     = $clog2(START_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              sel_valid;
  logic [ID_W-1:0]   sel_idx;
  logic [DATA_W-1:0] sel_data;
  int                sel_dist;
  int                cand_dist;
  logic              accept;

  // Winner is the valid requester closest to the slot just after the last grant, wrapping at N_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_dist  = N_REQ;
    cand_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i > int'(last_grant_q)) cand_dist = i - int'(last_grant_q) - 1;
      else                        cand_dist = i + N_REQ - int'(last_grant_q) - 1;
      if (req_valid[i] && (cand_dist < sel_dist)) begin
        sel_valid = 1'b1;
        sel_idx   = ID_W'(i);
        sel_dist  = cand_dist;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Reset gating keeps req_ready low while rst is held, even though the state already reads IDLE.
  assign accept = rst && (state_q == IDLE) && !tx_busy && sel_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d    = sel_data;
          grant_id_d   = sel_idx;
          last_grant_d = sel_idx;
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                 state_d = WAIT_DONE;
        else if (cnt_q == CNT_LAST)  state_d = IDLE;
        else if (cnt_q != '1)        cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = accept ? (N_REQ'(1) << sel_idx) : '0;
    tx_start  = (state_q == START);
    done      = (state_q == WAIT_DONE) && !tx_busy;
    err       = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == CNT_LAST);
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a simple transmitter busy model and a
// transaction-level round-robin predictor drive immediate-assertion checks on every cycle of each frame.
module tb_uart_tx_arbiter;

  localparam int N_REQ         = 2;
  localparam int DATA_W        = 8;
  localparam int START_TIMEOUT = 16;
  localparam int ID_W          = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic [ID_W-1:0]         grant_id;
  logic                    done;
  logic                    err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         modelLast;
  int         modelId;
  logic [7:0] modelData;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic busy);
    tx_busy = busy;
    #1;
  endtask

  task automatic refreshReq();
    req_valid[0]     = (q0.size() > 0);
    req_data[7:0]    = (q0.size() > 0) ? q0[0] : 8'($urandom);
    req_valid[1]     = (q1.size() > 0);
    req_data[15:8]   = (q1.size() > 0) ? q1[0] : 8'($urandom);
  endtask

  // Round robin as a rule: first pending index after the last grant, counting upward modulo N_REQ.
  function automatic int expectGrant(input int last, input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] shifted;
    for (int k = 1; k <= N_REQ; k++) begin
      shifted = v >> ((last + k) % N_REQ);
      if (shifted[0]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic doReset(input int holdCycles);
    rst = 1'b0;
    #1;
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    modelLast = N_REQ - 1;
    modelId   = 0;
    modelData = 8'h00;
    for (int i = 0; i < holdCycles; i++) nextCycle();
    rst = 1'b1;
  endtask

  // Entered at the drive point of an IDLE cycle; tx_busy is held high for the first 'hold' cycles.
  task automatic acceptOne(input int hold, output int gid, output bit ok);
    int               expIdx;
    logic [N_REQ-1:0] expReady;
    ok  = 1'b0;
    gid = -1;
    for (int i = 0; i < hold + 8; i++) begin
      if (i > 0) nextCycle();
      applyStimulus(i < hold);
      expIdx   = (i < hold) ? -1 : expectGrant(modelLast, req_valid);
      expReady = (expIdx < 0) ? '0 : (N_REQ'(1) << expIdx);
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("idle_tx_data", 32'(tx_data), 32'(modelData));
      checkOutput("idle_grant_id", 32'(grant_id), 32'(modelId));
      checkOutput("idle_pulses", 32'({tx_start, done, err}), 32'd0);
      if (expIdx >= 0) begin
        gid = expIdx;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_wait", 32'd0, 32'd1);
  endtask

  // One full transaction; busyDelay > START_TIMEOUT models a transmitter that never responds.
  task automatic runFrame(input int hold, input int busyDelay, input int busyLen);
    int         gid;
    bit         ok;
    logic [7:0] expData;
    acceptOne(hold, gid, ok);
    if (!ok) return;
    expData = (gid == 0) ? q0[0] : q1[0];
    nextCycle();
    if (gid == 0) void'(q0.pop_front());
    else          void'(q1.pop_front());
    refreshReq();
    modelLast = gid;
    modelId   = gid;
    modelData = expData;
    applyStimulus(1'b0);
    checkOutput("tx_start", 32'(tx_start), 32'd1);
    checkOutput("tx_data", 32'(tx_data), 32'(expData));
    checkOutput("grant_id", 32'(grant_id), 32'(gid));
    checkOutput("start_ready", 32'(req_ready), 32'd0);
    if (busyDelay > START_TIMEOUT) begin
      for (int k = 1; k <= START_TIMEOUT; k++) begin
        nextCycle();
        applyStimulus(1'b0);
        checkOutput("timeout_err", 32'(err), 32'(k == START_TIMEOUT));
        checkOutput("timeout_other", 32'({req_ready, tx_start, done}), 32'd0);
      end
    end else begin
      for (int k = 1; k < busyDelay; k++) begin
        nextCycle();
        applyStimulus(1'b0);
        checkOutput("wait_busy_flags", 32'({req_ready, tx_start, done, err}), 32'd0);
      end
      for (int k = 0; k < busyLen; k++) begin
        nextCycle();
        applyStimulus(1'b1);
        checkOutput("frame_flags", 32'({req_ready, tx_start, done, err}), 32'd0);
      end
      nextCycle();
      applyStimulus(1'b0);
      checkOutput("done", 32'(done), 32'd1);
      checkOutput("done_err", 32'(err), 32'd0);
    end
    nextCycle();
  endtask

  initial begin
    int gid;
    bit ok;
    rst       = 1'b0;
    tx_busy   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    refreshReq();
    nextCycle();
    doReset(2);

    $display("[TB] single byte from requester 0");
    q0.push_back(8'h30);
    refreshReq();
    runFrame(0, 2, 20);

    $display("[TB] both requesters back to back");
    doReset(1);
    q0.push_back(8'h41); q0.push_back(8'h41);
    q1.push_back(8'h42); q1.push_back(8'h42);
    refreshReq();
    for (int n = 0; n < 4; n++) runFrame(0, 2, 3);

    $display("[TB] requester 1 alone");
    q1.push_back(8'h31); q1.push_back(8'h32); q1.push_back(8'h33);
    refreshReq();
    for (int n = 0; n < 3; n++) runFrame(0, 1, 2);

    $display("[TB] start timeout then recovery");
    q0.push_back(8'h44);
    refreshReq();
    runFrame(0, START_TIMEOUT + 1, 1);
    q1.push_back(8'h45);
    refreshReq();
    runFrame(0, 2, 3);

    $display("[TB] reset during frame");
    q0.push_back(8'h70);
    refreshReq();
    acceptOne(0, gid, ok);
    nextCycle();
    void'(q0.pop_front());
    refreshReq();
    applyStimulus(1'b0);
    checkOutput("pre_rst_start", 32'(tx_start), 32'd1);
    nextCycle();
    applyStimulus(1'b1);
    nextCycle();
    applyStimulus(1'b1);
    q0.push_back(8'h71);
    q1.push_back(8'h72);
    refreshReq();
    #1;
    doReset(1);
    runFrame(3, 2, 4);

    $display("[TB] busy held in idle");
    q0.push_back(8'h66);
    refreshReq();
    runFrame(4, 1, 2);
    runFrame(0, 3, 2);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 24; n++) begin
      int pushes;
      pushes = $urandom_range(0, 2);
      for (int p = 0; p < pushes; p++) begin
        if ($urandom_range(0, 1) == 0) q0.push_back(8'($urandom));
        else                           q1.push_back(8'($urandom));
      end
      if ((q0.size() == 0) && (q1.size() == 0)) q1.push_back(8'($urandom));
      refreshReq();
      runFrame($urandom_range(0, 2), $urandom_range(1, START_TIMEOUT + 3), $urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
